// File: rtl/riscv_decoder.sv
// ---------------------------------------------------------------------------
// riscv_decoder
//   RV32I instruction decoder that sits between register-file read and the
//   ALU/LSU. It turns one instruction word into ALU operands, an ALU op,
//   writeback controls, memory controls and PC-select controls. All outputs
//   are registered, so they appear one clock after the inputs.
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   instruction       in   [31:0] instruction word
//   reg_read_data1    in   [31:0] rs1 value
//   reg_read_data2    in   [31:0] rs2 value
//   pc                in   [31:0] PC of the instruction
//   alu_operand_a     out  [31:0] ALU input A
//   alu_operand_b     out  [31:0] ALU input B
//   alu_control       out  [3:0]  ALU op (ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4
//                                  XOR=5 SRL=6 SRA=7 OR=8 AND=9)
//   reg_write_enable  out  write rd
//   reg_write_dest    out  [4:0] rd index, 0 when no write
//   mem_read_enable   out  load
//   mem_write_enable  out  store
//   mem_to_reg        out  writeback from memory
//   branch_enable     out  conditional branch
//   jump_enable       out  JAL/JALR
//   next_pc_select    out  [1:0] 0=PC+4 1=branch 2=JAL 3=JALR
// ---------------------------------------------------------------------------
module riscv_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] reg_read_data1,
    input  logic [31:0] reg_read_data2,
    input  logic [31:0] pc,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [3:0]  alu_control,
    output logic        reg_write_enable,
    output logic [4:0]  reg_write_dest,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic        mem_to_reg,
    output logic        branch_enable,
    output logic        jump_enable,
    output logic [1:0]  next_pc_select
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_u;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];
    assign rd        = instruction[11:7];
    assign imm_i     = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s     = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_u     = {instruction[31:12], 12'b0};

    logic [31:0] alu_operand_a_d, alu_operand_a_q;
    logic [31:0] alu_operand_b_d, alu_operand_b_q;
    logic [3:0]  alu_control_d, alu_control_q;
    logic        reg_write_enable_d, reg_write_enable_q;
    logic [4:0]  reg_write_dest_d, reg_write_dest_q;
    logic        mem_read_enable_d, mem_read_enable_q;
    logic        mem_write_enable_d, mem_write_enable_q;
    logic        mem_to_reg_d, mem_to_reg_q;
    logic        branch_enable_d, branch_enable_q;
    logic        jump_enable_d, jump_enable_q;
    logic [1:0]  next_pc_select_d, next_pc_select_q;

    // Shared funct3 -> ALU op mapping for OP and OP-IMM. The SUB/SRA
    // selector is passed in so OP-IMM can suppress SUB (ADDI has no SUBI).
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic sub_ok,
                                            input logic f7b5);
        case (f3)
            3'b000:  arith_op = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // Defaults describe the NOP, so any unrecognised opcode falls out of
    // the case with every enable low and zero operands.
    always_comb begin
        alu_operand_a_d    = '0;
        alu_operand_b_d    = '0;
        alu_control_d      = ALU_ADD;
        reg_write_enable_d = 1'b0;
        reg_write_dest_d   = '0;
        mem_read_enable_d  = 1'b0;
        mem_write_enable_d = 1'b0;
        mem_to_reg_d       = 1'b0;
        branch_enable_d    = 1'b0;
        jump_enable_d      = 1'b0;
        next_pc_select_d   = 2'd0;

        case (opcode)
            OPC_OP: begin
                alu_operand_a_d    = reg_read_data1;
                alu_operand_b_d    = reg_read_data2;
                alu_control_d      = arith_op(funct3, 1'b1, funct7_b5);
                reg_write_enable_d = 1'b1;
                reg_write_dest_d   = rd;
            end
            OPC_OP_IMM: begin
                alu_operand_a_d    = reg_read_data1;
                alu_operand_b_d    = imm_i;
                alu_control_d      = arith_op(funct3, 1'b0, funct7_b5);
                reg_write_enable_d = 1'b1;
                reg_write_dest_d   = rd;
            end
            OPC_LOAD: begin
                alu_operand_a_d    = reg_read_data1;
                alu_operand_b_d    = imm_i;
                mem_read_enable_d  = 1'b1;
                mem_to_reg_d       = 1'b1;
                reg_write_enable_d = 1'b1;
                reg_write_dest_d   = rd;
            end
            OPC_STORE: begin
                alu_operand_a_d    = reg_read_data1;
                alu_operand_b_d    = imm_s;
                mem_write_enable_d = 1'b1;
            end
            OPC_BRANCH: begin
                alu_operand_a_d  = reg_read_data1;
                alu_operand_b_d  = reg_read_data2;
                branch_enable_d  = 1'b1;
                next_pc_select_d = 2'd1;
                // funct3[2:1]: 00 BEQ/BNE, 10 BLT/BGE, 11 BLTU/BGEU
                case (funct3[2:1])
                    2'b10:   alu_control_d = ALU_SLT;
                    2'b11:   alu_control_d = ALU_SLTU;
                    default: alu_control_d = ALU_SUB;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                // ALU computes the link value; the target comes from the PC unit.
                alu_operand_a_d    = pc;
                alu_operand_b_d    = 32'd4;
                jump_enable_d      = 1'b1;
                next_pc_select_d   = (opcode == OPC_JAL) ? 2'd2 : 2'd3;
                reg_write_enable_d = 1'b1;
                reg_write_dest_d   = rd;
            end
            OPC_LUI: begin
                alu_operand_b_d    = imm_u;
                reg_write_enable_d = 1'b1;
                reg_write_dest_d   = rd;
            end
            OPC_AUIPC: begin
                alu_operand_a_d    = pc;
                alu_operand_b_d    = imm_u;
                reg_write_enable_d = 1'b1;
                reg_write_dest_d   = rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_operand_a_q    <= '0;
            alu_operand_b_q    <= '0;
            alu_control_q      <= ALU_ADD;
            reg_write_enable_q <= 1'b0;
            reg_write_dest_q   <= '0;
            mem_read_enable_q  <= 1'b0;
            mem_write_enable_q <= 1'b0;
            mem_to_reg_q       <= 1'b0;
            branch_enable_q    <= 1'b0;
            jump_enable_q      <= 1'b0;
            next_pc_select_q   <= 2'd0;
        end else begin
            alu_operand_a_q    <= alu_operand_a_d;
            alu_operand_b_q    <= alu_operand_b_d;
            alu_control_q      <= alu_control_d;
            reg_write_enable_q <= reg_write_enable_d;
            reg_write_dest_q   <= reg_write_dest_d;
            mem_read_enable_q  <= mem_read_enable_d;
            mem_write_enable_q <= mem_write_enable_d;
            mem_to_reg_q       <= mem_to_reg_d;
            branch_enable_q    <= branch_enable_d;
            jump_enable_q      <= jump_enable_d;
            next_pc_select_q   <= next_pc_select_d;
        end
    end

    assign alu_operand_a    = alu_operand_a_q;
    assign alu_operand_b    = alu_operand_b_q;
    assign alu_control      = alu_control_q;
    assign reg_write_enable = reg_write_enable_q;
    assign reg_write_dest   = reg_write_dest_q;
    assign mem_read_enable  = mem_read_enable_q;
    assign mem_write_enable = mem_write_enable_q;
    assign mem_to_reg       = mem_to_reg_q;
    assign branch_enable    = branch_enable_q;
    assign jump_enable      = jump_enable_q;
    assign next_pc_select   = next_pc_select_q;

endmodule

// File: tb/tb_riscv_decoder.sv
// ---------------------------------------------------------------------------
// tb_riscv_decoder
//   Directed table of instructions with hand-decoded expected outputs, plus
//   short hand-written reset sequences (initial reset, asynchronous mid-stream
//   reset, outputs holding zero until the first edge after release).
// ---------------------------------------------------------------------------
module tb_riscv_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] reg_read_data1 = 32'h100;
    logic [31:0] reg_read_data2 = 32'h20;
    logic [31:0] pc = 32'h8000_0000;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic [3:0]  alu_control;
    logic        reg_write_enable;
    logic [4:0]  reg_write_dest;
    logic        mem_read_enable, mem_write_enable, mem_to_reg;
    logic        branch_enable, jump_enable;
    logic [1:0]  next_pc_select;

    riscv_decoder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instruction      (instruction),
        .reg_read_data1   (reg_read_data1),
        .reg_read_data2   (reg_read_data2),
        .pc               (pc),
        .alu_operand_a    (alu_operand_a),
        .alu_operand_b    (alu_operand_b),
        .alu_control      (alu_control),
        .reg_write_enable (reg_write_enable),
        .reg_write_dest   (reg_write_dest),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_to_reg       (mem_to_reg),
        .branch_enable    (branch_enable),
        .jump_enable      (jump_enable),
        .next_pc_select   (next_pc_select)
    );

    always #5 clk = ~clk;

    // {A, B, ctl, we, dest, mr, mw, m2r, br, j, nps}
    typedef logic [80:0] outs_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        outs_t       exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic outs_t pk(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] ctl, input logic we,
                                 input logic [4:0] dest, input logic mr,
                                 input logic mw, input logic m2r, input logic br,
                                 input logic j, input logic [1:0] nps);
        pk = {a, b, ctl, we, dest, mr, mw, m2r, br, j, nps};
    endfunction

    function automatic outs_t actual();
        actual = {alu_operand_a, alu_operand_b, alu_control, reg_write_enable,
                  reg_write_dest, mem_read_enable, mem_write_enable, mem_to_reg,
                  branch_enable, jump_enable, next_pc_select};
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = actual();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    localparam logic [31:0] PC0 = 32'h8000_0000;
    vec_t vecs[$];

    initial begin
        outs_t zero;
        zero = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{"ADD",      32'h002081B3, pk(32'h100, 32'h20, 0, 1, 3, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"ADDI",     32'h00A08213, pk(32'h100, 32'hA, 0, 1, 4, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"LW",       32'h0040A283, pk(32'h100, 32'h4, 0, 1, 5, 1, 0, 1, 0, 0, 0)});
        vecs.push_back('{"SW",       32'h00212423, pk(32'h100, 32'h8, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"BEQ",      32'h00C08663, pk(32'h100, 32'h20, 1, 0, 0, 0, 0, 0, 1, 0, 1)});
        vecs.push_back('{"JAL",      32'h0140036F, pk(PC0, 32'h4, 0, 1, 6, 0, 0, 0, 0, 1, 2)});
        vecs.push_back('{"LUI",      32'h012345B7, pk(32'h0, 32'h01234000, 0, 1, 11, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"AUIPC",    32'h0ABCDE97, pk(PC0, 32'h0ABCD000, 0, 1, 29, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"NOP_7F",   32'h0000007F, zero});
        vecs.push_back('{"SUB",      32'h40208233, pk(32'h100, 32'h20, 1, 1, 4, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"XOR",      32'h0020C233, pk(32'h100, 32'h20, 5, 1, 4, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"ADDI_b30", 32'h40008213, pk(32'h100, 32'h400, 0, 1, 4, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"SRAI",     32'h4030D213, pk(32'h100, 32'h403, 7, 1, 4, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"ADDI_neg", 32'hFFF08213, pk(32'h100, 32'hFFFFFFFF, 0, 1, 4, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"SW_neg",   32'hFE20AE23, pk(32'h100, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"BLT",      32'h00C0C663, pk(32'h100, 32'h20, 3, 0, 0, 0, 0, 0, 1, 0, 1)});
        vecs.push_back('{"BLTU",     32'h00C0E663, pk(32'h100, 32'h20, 4, 0, 0, 0, 0, 0, 1, 0, 1)});
        vecs.push_back('{"JALR",     32'h000100E7, pk(PC0, 32'h4, 0, 1, 1, 0, 0, 0, 0, 1, 3)});
        vecs.push_back('{"ECALL",    32'h00000073, zero});

        // Reset state, with a live instruction on the inputs.
        instruction = 32'h002081B3;
        repeat (2) @(posedge clk);
        #1 check("reset_hold", zero);

        // Release between edges: outputs stay zero until the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_release", zero);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            instruction = vecs[i].ins;
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp);
        end

        // Mid-stream asynchronous reset: load a non-zero decode, then pull
        // rst_n low well away from any edge and look before the next edge.
        @(negedge clk);
        instruction = 32'h0140036F;
        @(posedge clk);
        #1 check("pre_async", pk(PC0, 32'h4, 0, 1, 6, 0, 0, 0, 0, 1, 2));
        #2 rst_n = 1'b0;
        #1 check("async_reset", zero);
        @(negedge clk);
        rst_n = 1'b1;
        instruction = 32'h0040A283;
        @(posedge clk);
        #1 check("after_reset_LW", pk(32'h100, 32'h4, 0, 1, 5, 1, 0, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
